prog_timer: RTL and testbench
=============================

# prog_timer

Programmable tick timer generalising the fixed up-counter timer: a prescaler divides `clk` into one tick every FREQ cycles, and a WIDTH-bit counter steps once per tick. The counter counts up or down over a runtime limit, in periodic or one-shot mode, with pause, clear and load controls. It sits between the board clock and display/sequencing logic, providing the count value plus `tick`/`done` pulses.

## Interface
- FREQ, 10: clk cycles per tick (≥1); 100_000_000 on hardware.
- WIDTH, 8: counter width.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  run request, level; registered once (`enable_sync`) before use.
- clear  in  1  one-cycle pulse; count to start value, prescaler to 0.
- load  in  1  one-cycle pulse; count <= load_value, saturated to limit.
- load_value  in  WIDTH  load data.
- limit  in  WIDTH  terminal/start bound.
- dir  in  1  0 up (start 0, terminal limit), 1 down (start limit, terminal 0).
- mode  in  1  0 periodic, 1 one-shot.
- count  out  WIDTH  current value, registered.
- tick  out  1  one-cycle pulse on every count step.
- done  out  1  one-cycle pulse when count steps into terminal.
- running  out  1  high in state RUN.

## Operation
- States: IDLE, RUN, EXPIRED. Reset -> IDLE.
- IDLE -> RUN when enable_sync=1; RUN -> IDLE when enable_sync=0 (pause: count and prescaler hold, tick forced 0).
- RUN: prescaler counts 0..FREQ-1; on the edge where it wraps, count steps and tick=1.
- Step: up: count>=limit -> 0, else +1; down: count==0 -> limit, count>limit -> limit, else -1.
- done=1 with the step whose new count equals terminal (limit up, 0 down); no done on wrap.
- One-shot: step producing done also enters EXPIRED; count holds, prescaler stops, running=0. EXPIRED exits only via clear, load or rst, to IDLE (next cycle RUN if enable_sync=1).
- Periodic: terminal value holds one tick, then wraps to start value.
- limit==0: every tick yields count 0 with done=1; one-shot expires on first tick.
- dir, mode, limit sampled at each step; changes take effect at the next step.
- Priority: rst > clear > load > step. clear/load also reset prescaler to 0 and suppress that cycle's tick/done.

## Timing
- Reset values: count 0, tick 0, done 0, running 0, prescaler 0, enable_sync 0.
- enable sampled high at edge E0 -> running=1 after E1; first step at edge E0+FREQ; subsequent steps every FREQ edges.
- tick, done, count update on the same edge; all outputs registered, no combinational input-to-output paths.
- clear/load: count valid the cycle after the pulse.
- Pause/resume keeps prescaler phase: total running cycles per step is always FREQ.

## Configuration
- `TIMER_CAPTURE_EN` defined: adds ports `capture` (in, 1) and `cap_value` (out, WIDTH, reset 0); `capture`=1 latches `count` into `cap_value` at that edge, in any state; if coincident with a step, the pre-step value is captured.
- Undefined: ports and register absent; all other behaviour identical.

## Structure
- Package `timer_pkg`: state enum (T_IDLE, T_RUN, T_EXPIRED), DIR_UP/DIR_DOWN, MODE_PERIODIC/MODE_ONESHOT constants.
- Sub-module `tick_prescaler` (param FREQ; in clk, rst, en, clr; out wrap pulse), counter width $clog2(FREQ+1).

## Test plan
- FREQ=4, limit=3, up periodic, enable held -> count 1,2,3,0,1 at E0+4,+8,+12,+16,+20; done only at +12; tick at each.
- Down one-shot, limit=2, clear first -> count 2,1,0; done at the step to 0; running drops; count holds 0 for 20 further cycles; clear -> count 2.
- Drop enable 2 cycles into a tick period for 10 cycles -> count and tick frozen; next step 2 cycles after enable_sync returns.
- load_value=200, limit=3 -> count 3; load coincident with a step -> count=load result, no tick/done.
- limit=0 periodic -> done and tick every 4 cycles, count stays 0; rst mid-run -> all outputs 0 after the next edge, state IDLE.
- With TIMER_CAPTURE_EN: capture on a step edge where count 1->2 -> cap_value=1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the programmable tick timer.
package timer_pkg;

  typedef enum logic [1:0] {
    T_IDLE,
    T_RUN,
    T_EXPIRED
  } timer_state_t;

  localparam logic DIR_UP        = 1'b0;
  localparam logic DIR_DOWN      = 1'b1;
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk by FREQ: wrap pulses on the enabled cycle that closes each period.
module tick_prescaler #(
  parameter int FREQ = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic wrap
);

  localparam int CW = $clog2(FREQ + 1);

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == CW'(FREQ - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable up/down tick timer with periodic/one-shot modes, pause, clear and load.
// Optional macro TIMER_CAPTURE_EN adds a capture input and cap_value register.
module prog_timer
  import timer_pkg::*;
#(
  parameter int FREQ  = 10,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef TIMER_CAPTURE_EN
  input  logic             capture,
  output logic [WIDTH-1:0] cap_value,
`endif
  input  logic             enable,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             dir,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             running
);

  timer_state_t     state, state_next;
  logic             enable_sync;
  logic             wrap;
  logic             ctl;
  logic             step;
  logic             step_done;
  logic [WIDTH-1:0] count_step;

  function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] lim,
                                                   input logic             d);
    if (d == DIR_UP) return (cur >= lim) ? '0 : cur + 1'b1;
    else if (cur == '0 || cur > lim) return lim;
    else return cur - 1'b1;
  endfunction

  function automatic logic [WIDTH-1:0] load_sat(input logic [WIDTH-1:0] val,
                                                 input logic [WIDTH-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  // Prescaler advances on enable_sync so the first step lands FREQ edges after enable is sampled.
  tick_prescaler #(.FREQ(FREQ)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (enable_sync && (state != T_EXPIRED)),
    .clr  (ctl),
    .wrap (wrap)
  );

  assign ctl        = clear | load;
  assign step       = wrap && !ctl;
  assign count_step = step_value(count, limit, dir);
  assign step_done  = (count_step == ((dir == DIR_DOWN) ? '0 : limit));

  always_comb begin
    state_next = state;
    if (ctl) begin
      state_next = T_IDLE;
    end else begin
      case (state)
        T_IDLE:  if (enable_sync) state_next = T_RUN;
        T_RUN:   if (!enable_sync) state_next = T_IDLE;
        default: state_next = state;
      endcase
    end
    if (step && step_done && (mode == MODE_ONESHOT)) state_next = T_EXPIRED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= T_IDLE;
      enable_sync <= 1'b0;
      count       <= '0;
      tick        <= 1'b0;
      done        <= 1'b0;
      running     <= 1'b0;
    end else begin
      state       <= state_next;
      enable_sync <= enable;
      running     <= (state_next == T_RUN);
      tick        <= step;
      done        <= step && step_done;
      if (clear)     count <= (dir == DIR_DOWN) ? limit : '0;
      else if (load) count <= load_sat(load_value, limit);
      else if (step) count <= count_step;
    end
  end

`ifdef TIMER_CAPTURE_EN
  // Captures the pre-step value when coincident with a step.
  always_ff @(posedge clk) begin
    if (rst)          cap_value <= '0;
    else if (capture) cap_value <= count;
  end
`endif

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: vector table, directed corner sequences, random vs model.
module tb_prog_timer;

  localparam int FREQ  = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst, enable, clear, load, dir, mode;
  logic [WIDTH-1:0] load_value, limit, count;
  logic             tick, done, running;
`ifdef TIMER_CAPTURE_EN
  logic             capture;
  logic [WIDTH-1:0] cap_value;
  int               m_cap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_cnt, m_phase;
  bit m_ens, m_expired, m_run, m_tick, m_done;

  always #5 clk = ~clk;

  prog_timer #(.FREQ(FREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TIMER_CAPTURE_EN
    .capture    (capture),
    .cap_value  (cap_value),
`endif
    .enable     (enable),
    .clear      (clear),
    .load       (load),
    .load_value (load_value),
    .limit      (limit),
    .dir        (dir),
    .mode       (mode),
    .count      (count),
    .tick       (tick),
    .done       (done),
    .running    (running)
  );

  typedef struct {
    logic rst, en, clr, ld;
    int   lv, lim;
    logic dir, mode;
    int   c;
    logic t, d, r;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a step happens after FREQ cycles with enable_sync high while not expired.
  task automatic model_edge();
    int lim, c;
    if (rst) begin
      m_cnt = 0; m_phase = 0; m_ens = 0; m_expired = 0;
      m_run = 0; m_tick = 0; m_done = 0;
`ifdef TIMER_CAPTURE_EN
      m_cap = 0;
`endif
      return;
    end
    lim = int'(limit);
    m_tick = 0;
    m_done = 0;
`ifdef TIMER_CAPTURE_EN
    if (capture) m_cap = m_cnt;
`endif
    if (clear || load) begin
      if (clear) m_cnt = dir ? lim : 0;
      else       m_cnt = (int'(load_value) > lim) ? lim : int'(load_value);
      m_phase = 0;
      m_expired = 0;
      m_run = 0;
    end else begin
      if (m_ens && !m_expired) begin
        m_phase++;
        if (m_phase == FREQ) begin
          m_phase = 0;
          c = m_cnt;
          if (!dir) c = (c >= lim) ? 0 : c + 1;
          else      c = (c == 0 || c > lim) ? lim : c - 1;
          m_cnt  = c;
          m_tick = 1;
          m_done = (c == (dir ? 0 : lim));
          if (mode && m_done) m_expired = 1;
        end
      end
      m_run = m_ens && !m_expired;
    end
    m_ens = enable;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_count", count, m_cnt);
    chk("model_tick", tick, m_tick);
    chk("model_done", done, m_done);
    chk("model_running", running, m_run);
`ifdef TIMER_CAPTURE_EN
    chk("model_cap_value", cap_value, m_cap);
`endif
  endtask

  task automatic wait_tick(input string name, input int maxc);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!tick && k < maxc);
    chk({name, "_tick_seen"}, tick, 1);
  endtask

  initial begin
    int ticks, dones;
    logic [WIDTH-1:0] frozen;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0;
    load_value = '0; limit = '0; dir = 1'b0; mode = 1'b0;
`ifdef TIMER_CAPTURE_EN
    capture = 1'b0;
`endif

    // rst en clr ld lv lim dir mode | count tick done running
    tbl[0]  = '{1, 0, 0, 0,   0, 3, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 1};
    tbl[3]  = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 1};
    tbl[4]  = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 1};
    tbl[5]  = '{0, 1, 0, 0,   0, 3, 0, 0, 1, 1, 0, 1};
    tbl[6]  = '{0, 1, 0, 0,   0, 3, 0, 0, 1, 0, 0, 1};
    tbl[7]  = '{0, 1, 0, 0,   0, 3, 0, 0, 1, 0, 0, 1};
    tbl[8]  = '{0, 1, 0, 0,   0, 3, 0, 0, 1, 0, 0, 1};
    tbl[9]  = '{0, 1, 0, 0,   0, 3, 0, 0, 2, 1, 0, 1};
    tbl[10] = '{0, 1, 0, 0,   0, 3, 0, 0, 2, 0, 0, 1};
    tbl[11] = '{0, 1, 0, 0,   0, 3, 0, 0, 2, 0, 0, 1};
    tbl[12] = '{0, 1, 0, 0,   0, 3, 0, 0, 2, 0, 0, 1};
    tbl[13] = '{0, 1, 0, 0,   0, 3, 0, 0, 3, 1, 1, 1};
    tbl[14] = '{0, 1, 0, 0,   0, 3, 0, 0, 3, 0, 0, 1};
    tbl[15] = '{0, 1, 0, 0,   0, 3, 0, 0, 3, 0, 0, 1};
    tbl[16] = '{0, 1, 0, 0,   0, 3, 0, 0, 3, 0, 0, 1};
    tbl[17] = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 1, 0, 1};
    tbl[18] = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 1};
    tbl[19] = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 1};
    tbl[20] = '{0, 1, 0, 0,   0, 3, 0, 0, 0, 0, 0, 1};
    tbl[21] = '{0, 1, 0, 0,   0, 3, 0, 0, 1, 1, 0, 1};
    tbl[22] = '{0, 1, 0, 1, 200, 3, 0, 0, 3, 0, 0, 0};

    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; enable = tbl[i].en; clear = tbl[i].clr; load = tbl[i].ld;
      load_value = WIDTH'(tbl[i].lv); limit = WIDTH'(tbl[i].lim);
      dir = tbl[i].dir; mode = tbl[i].mode;
      cyc();
      chk($sformatf("tbl%0d_count", i), count, tbl[i].c);
      chk($sformatf("tbl%0d_tick", i), tick, tbl[i].t);
      chk($sformatf("tbl%0d_done", i), done, tbl[i].d);
      chk($sformatf("tbl%0d_running", i), running, tbl[i].r);
    end
    load = 1'b0;

    // Down one-shot expiry and hold
    dir = 1'b1; mode = 1'b1; limit = 8'd2; clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("dn_clear_count", count, 2);
    wait_tick("dn_step1", 20);
    chk("dn_step1_count", count, 1);
    wait_tick("dn_step2", 20);
    chk("dn_step2_count", count, 0);
    chk("dn_step2_done", done, 1);
    chk("dn_expired_running", running, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("dn_hold_count", count, 0);
      chk("dn_hold_tick", tick, 0);
    end
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("dn_reclear_count", count, 2);

    // Pause mid-period keeps prescaler phase
    dir = 1'b0; mode = 1'b0; limit = 8'd5; clear = 1'b1;
    cyc();
    clear = 1'b0;
    wait_tick("pause_sync", 20);
    cyc();
    enable = 1'b0;
    cyc();
    frozen = count;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pause_tick", tick, 0);
      chk("pause_count", count, frozen);
    end
    enable = 1'b1;
    cyc();
    chk("resume_e1_tick", tick, 0);
    cyc();
    chk("resume_e2_tick", tick, 0);
    cyc();
    chk("resume_step_tick", tick, 1);
    chk("resume_step_count", count, frozen + 1);

    // Load saturation and load coincident with a step
    limit = 8'd3; load_value = 8'd200; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_sat_count", count, 3);
    wait_tick("load_sync", 20);
    repeat (FREQ - 1) cyc();
    load_value = 8'd1; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("load_step_count", count, 1);
    chk("load_step_tick", tick, 0);
    chk("load_step_done", done, 0);

    // limit==0 periodic, then reset mid-run
    limit = 8'd0; clear = 1'b1;
    cyc();
    clear = 1'b0;
    ticks = 0; dones = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      chk("lim0_count", count, 0);
      ticks += int'(tick);
      dones += int'(done);
    end
    chk("lim0_ticks", ticks, 3);
    chk("lim0_dones", dones, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    chk("rst_running", running, 0);

`ifdef TIMER_CAPTURE_EN
    limit = 8'd5; clear = 1'b1;
    cyc();
    clear = 1'b0;
    wait_tick("cap_sync", 20);
    repeat (FREQ - 1) cyc();
    capture = 1'b1;
    cyc();
    capture = 1'b0;
    chk("cap_value_prestep", cap_value, 1);
    chk("cap_count_after", count, 2);
`endif

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 99) == 0);
      enable = ($urandom_range(0, 9) < 8);
      clear  = ($urandom_range(0, 29) == 0);
      load   = ($urandom_range(0, 29) == 0);
      load_value = WIDTH'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) limit = WIDTH'($urandom_range(0, 6));
      if ($urandom_range(0, 19) == 0) dir  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) mode = 1'($urandom_range(0, 1));
`ifdef TIMER_CAPTURE_EN
      capture = ($urandom_range(0, 9) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
